// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction format, NOP encoding, store controller states.
package pipeline_pkg;

    localparam int unsigned IW_DEFAULT = 16;
    localparam logic [IW_DEFAULT-1:0] NOP_DEFAULT = 16'h0000;

    // Instruction format: opcode | op1 | op2 | function code.
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned OP1_W    = 4;
    localparam int unsigned OP2_W    = 4;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned OP1_LSB  = 8;
    localparam int unsigned OP2_LSB  = 4;
    localparam int unsigned FUNC_LSB = 0;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OP1_W-1:0]  op1;
        logic [OP2_W-1:0]  op2;
        logic [FUNC_W-1:0] func;
    } instr_fmt_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Extract the opcode field from a raw instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [IW_DEFAULT-1:0] word);
        return word[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Synchronous read-first instruction array: one write port, one registered read port, no reset.
module instr_ram #(
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];

    // Write and read in the same edge; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/instruction_store.sv
// Writable instruction memory for the IF stage: post-reset clear, program load, stall-holding fetch.
// DEPTH must be at least 2 so that AW is non-zero.
module instruction_store
    import pipeline_pkg::*;
#(
    parameter int unsigned   IW         = IW_DEFAULT,
    parameter int unsigned   DEPTH      = 16,
    parameter int unsigned   AW         = $clog2(DEPTH),
    parameter logic [IW-1:0] NOP        = IW'(NOP_DEFAULT),
    parameter bit            INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          fetch_req,
    input  logic [15:0]   fetch_addr,
    input  logic          fetch_stall,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          addr_fault,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_ld_ready;
    logic          r_valid;
    logic          r_fault;
    logic          r_nop_sel;

    logic          w_ld_in_range;
    logic          w_fetch_in_range;
    logic          w_clear_last;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [IW-1:0] w_ram_wdata;
    logic          w_ram_re;
    logic          w_fault_go;
    logic          w_idle_go;
    logic [IW-1:0] w_rdata;

    assign w_ld_in_range    = (32'(ld_addr) < DEPTH);
    assign w_fetch_in_range = (fetch_addr < 16'(DEPTH));
    assign w_clear_last     = (r_cnt == AW'(DEPTH - 1));

    // Next state plus array write/read and fetch-outcome strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_waddr = ld_addr;
        w_ram_wdata = ld_data;
        w_ram_re    = 1'b0;
        w_fault_go  = 1'b0;
        w_idle_go   = 1'b0;
        case (r_state)
            INIT: begin
                if (INIT_CLEAR) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = r_cnt;
                    w_ram_wdata = NOP;
                    if (w_clear_last) begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_ram_we = ld_en && w_ld_in_range;
                if (!fetch_stall) begin
                    if (fetch_req) begin
                        if (w_fetch_in_range) begin
                            w_ram_re = 1'b1;
                        end else begin
                            w_fault_go = 1'b1;
                        end
                    end else begin
                        w_idle_go = 1'b1;
                    end
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear-sequence address counter, advancing only while initialising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Registered, complementary busy / ld_ready flags tracking the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= 1'b1;
            r_ld_ready <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt == INIT);
            r_ld_ready <= (w_state_nxt == RUN);
        end
    end

    // Fetch status registers; r_nop_sel picks the NOP word over the array read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_nop_sel <= 1'b1;
        end else if (w_ram_re) begin
            r_valid   <= 1'b1;
            r_fault   <= 1'b0;
            r_nop_sel <= 1'b0;
        end else if (w_fault_go) begin
            r_valid   <= 1'b1;
            r_fault   <= 1'b1;
            r_nop_sel <= 1'b1;
        end else if (w_idle_go) begin
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
        end
    end

    instr_ram #(
        .IW    (IW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_instr_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (AW'(fetch_addr)),
        .o_rdata (w_rdata)
    );

    assign instr       = r_nop_sel ? NOP : w_rdata;
    assign instr_valid = r_valid;
    assign addr_fault  = r_fault;
    assign busy        = r_busy;
    assign ld_ready    = r_ld_ready;

endmodule

// File: tb/tb_instruction_store.sv
// Self-checking bench: one clearing instance and one retaining instance on shared inputs.
module tb_instruction_store;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_stall;

    logic [15:0] a_instr, b_instr;
    logic        a_valid, a_fault, a_busy, a_ready;
    logic        b_valid, b_fault, b_busy, b_ready;

    always #5 clk = ~clk;

    instruction_store #(.IW(16), .DEPTH(DEPTH), .NOP(16'h0000), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(a_ready), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .instr(a_instr), .instr_valid(a_valid),
        .addr_fault(a_fault), .busy(a_busy)
    );

    instruction_store #(.IW(16), .DEPTH(DEPTH), .NOP(16'h0000), .INIT_CLEAR(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(b_ready), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .instr(b_instr), .instr_valid(b_valid),
        .addr_fault(b_fault), .busy(b_busy)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t        qa[$];
    logic [15:0] qb[$];
    logic [15:0] model [DEPTH];
    int          checks   = 0;
    int          failures = 0;

    task automatic drive(input logic le, input logic [3:0] la, input logic [15:0] ldat,
                         input logic fr, input logic [15:0] fa, input logic fs);
        @(negedge clk);
        ld_en = le; ld_addr = la; ld_data = ldat;
        fetch_req = fr; fetch_addr = fa; fetch_stall = fs;
        if (le) model[la] = ldat;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; ld_en = 0; ld_addr = 0; ld_data = 0;
        fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
        #12;
        checks++;
        if ({a_busy, a_ready, a_instr, a_valid, a_fault} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_a got busy=%b rdy=%b instr=%h v=%b f=%b exp 1 0 0000 0 0",
                     a_busy, a_ready, a_instr, a_valid, a_fault);
        end
        checks++;
        if ({b_busy, b_ready, b_instr, b_valid} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL reset_b got busy=%b rdy=%b instr=%h v=%b exp 1 0 0000 0",
                     b_busy, b_ready, b_instr, b_valid);
        end
        // Release with a fetch pending; it must be ignored while clearing.
        @(negedge clk);
        rst = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd5;
        for (int i = 1; i <= 16; i++) begin
            edge_sample();
            checks++;
            if ({a_busy, a_ready, a_valid} !== {(i < 16), (i >= 16), 1'b0}) begin
                failures++;
                $display("FAIL clear_edge%0d got busy=%b rdy=%b v=%b exp %b %b 0",
                         i, a_busy, a_ready, a_valid, (i < 16), (i >= 16));
            end
            if (i == 1) begin
                checks++;
                if ({b_busy, b_ready} !== 2'b01) begin
                    failures++;
                    $display("FAIL noclear_ready got busy=%b rdy=%b exp 0 1", b_busy, b_ready);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, 16'(k), 1'b0);
            qa.push_back('{instr: 16'h0000, valid: 1'b1, fault: 1'b0});
            edge_sample();
            e = qa.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL cleared_fetch%0d got %h %b %b exp %h %b %b",
                         k, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
        end
    endtask

    task automatic test_load_fetch();
        exp_t        e;
        logic [15:0] prog [4];
        prog = '{16'h1010, 16'h1231, 16'h145e, 16'h167f};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k), prog[k], 1'b0, 16'h0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, 16'(k), 1'b0);
            qa.push_back('{instr: prog[k], valid: 1'b1, fault: 1'b0});
            edge_sample();
            e = qa.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL b2b_fetch%0d got %h %b %b exp %h %b %b",
                         k, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
        end
        drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0);
        edge_sample();
        checks++;
        if ({a_instr, a_valid, a_fault} !== {16'h167f, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_hold got %h %b %b exp 167f 0 0", a_instr, a_valid, a_fault);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                drive(1'b0, 4'd0, 16'h0, 1'b1, 16'd2, 1'b0);
                qa.push_back('{instr: model[2], valid: 1'b1, fault: 1'b0});
            end else if (c < 4) begin
                // Load during a stall still lands; fetch is not serviced.
                drive((c == 2), 4'd3, 16'h3333, 1'b1, 16'd3, 1'b1);
                qa.push_back('{instr: model[2], valid: 1'b1, fault: 1'b0});
            end else begin
                drive(1'b0, 4'd0, 16'h0, 1'b1, 16'd3, 1'b0);
                qa.push_back('{instr: model[3], valid: 1'b1, fault: 1'b0});
            end
            edge_sample();
            e = qa.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL stall_c%0d got %h %b %b exp %h %b %b",
                         c, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
        end
    endtask

    task automatic test_fault();
        exp_t        e;
        logic [15:0] addrs [4];
        logic        stl   [4];
        addrs = '{16'h0010, 16'hFFFF, 16'h0000, 16'h0000};
        stl   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, addrs[c], stl[c]);
            if (c < 3) qa.push_back('{instr: 16'h0000, valid: 1'b1, fault: 1'b1});
            else       qa.push_back('{instr: model[0], valid: 1'b1, fault: 1'b0});
            edge_sample();
            e = qa.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL fault_c%0d got %h %b %b exp %h %b %b",
                         c, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
        end
    endtask

    task automatic test_same_cycle();
        exp_t        e;
        logic [15:0] old_word;
        for (int c = 0; c < 2; c++) begin
            old_word = model[1];
            drive((c == 0), 4'd1, 16'hABCD, 1'b1, 16'd1, 1'b0);
            qa.push_back('{instr: old_word, valid: 1'b1, fault: 1'b0});
            edge_sample();
            e = qa.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL read_first_c%0d got %h %b %b exp %h %b %b",
                         c, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        exp_t        e;
        logic [15:0] eb;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_valid, a_instr, b_busy, b_ready, b_valid} !==
            {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got a_busy=%b a_v=%b a_instr=%h b_busy=%b b_rdy=%b b_v=%b",
                     a_busy, a_valid, a_instr, b_busy, b_ready, b_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            edge_sample();
            checks++;
            if ({a_busy, a_ready} !== {(i < 16), (i >= 16)}) begin
                failures++;
                $display("FAIL reclear_edge%0d got busy=%b rdy=%b exp %b %b",
                         i, a_busy, a_ready, (i < 16), (i >= 16));
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, 16'(k), 1'b0);
            qa.push_back('{instr: 16'h0000, valid: 1'b1, fault: 1'b0});
            qb.push_back(model[k]);
            edge_sample();
            e  = qa.pop_front();
            eb = qb.pop_front();
            checks++;
            if ({a_instr, a_valid, a_fault} !== e) begin
                failures++;
                $display("FAIL recleared%0d got %h %b %b exp %h %b %b",
                         k, a_instr, a_valid, a_fault, e.instr, e.valid, e.fault);
            end
            checks++;
            if ({b_instr, b_valid, b_fault} !== {eb, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL retained%0d got %h %b %b exp %h 1 0",
                         k, b_instr, b_valid, b_fault, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_stall();
        test_fault();
        test_same_cycle();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
